pipe_skid_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, an optional two-entry skid buffer, synchronous flush with bubble injection, and a saturating back-pressure counter. It replaces the fixed-width, stall-only inter-stage registers (IF/ID first, then ID/EX, EX/MEM, MEM/WB). Upstream and downstream stalls propagate through the handshake instead of through a global stall net. When the stage holds no valid entry, downstream sees a configurable bubble word, such as a NOP instruction.

---
 rtl/pipe_skid_reg.sv | 114 +++++++++++
 tb/tb_pipe_skid_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid
// buffer, synchronous flush to a bubble word and a saturating stall counter.
module pipe_skid_reg #(
  parameter int unsigned       DATA_W      = 64,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = 64'h0000_0013_0000_0000,
  parameter int unsigned       SKID        = 1,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  main_q, main_d;
  logic [DATA_W-1:0]  skid_q, skid_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               up_fire;
  logic               dn_fire;

  assign up_fire = up_valid & up_ready;
  assign dn_fire = dn_valid & dn_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE_DATA;
      skid_q      <= BUBBLE_DATA;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE_DATA;
      skid_d  = BUBBLE_DATA;
    end else if (!hold) begin
      case (state_q)
        ST_EMPTY: begin
          if (up_fire) begin
            main_d  = up_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          // Without the skid entry an accept always coincides with a drain.
          if (up_fire && !dn_fire && (SKID != 0)) begin
            skid_d  = up_data;
            state_d = ST_TWO;
          end else if (up_fire) begin
            main_d = up_data;
          end else if (dn_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (dn_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (up_valid && !up_ready && !flush && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // With the skid entry, up_ready comes from state only, never from dn_ready.
  always_comb begin
    up_ready = 1'b0;
    if (!hold) begin
      if (SKID != 0) begin
        up_ready = (state_q != ST_TWO);
      end else begin
        up_ready = (state_q == ST_EMPTY) || dn_ready;
      end
    end
    dn_valid  = !hold && (state_q != ST_EMPTY);
    dn_data   = (state_q == ST_EMPTY) ? BUBBLE_DATA : main_q;
    occupancy = state_q;
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: a skid and a non-skid instance share stimulus and
// are both compared against a FIFO-level reference model every cycle.
module tb_pipe_skid_reg;

  localparam logic [63:0] BUB = 64'h0000_0013_0000_0000;

  logic        clk = 1'b0;
  logic        rst, flush, hold, up_valid, dn_ready;
  logic [63:0] up_data;

  logic        up_ready_s, dn_valid_s, up_ready_n, dn_valid_n;
  logic [63:0] dn_data_s, dn_data_n;
  logic [1:0]  occ_s, occ_n;
  logic [3:0]  cnt_s, cnt_n;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: per instance, an ordered list of held entries and a counter.
  logic [63:0] ent [2][2];
  int          n_ent [2];
  int          scnt [2];

  typedef struct {
    logic        rst, flush, hold, up_valid;
    logic [63:0] up_data;
    logic        dn_ready;
    logic        e_ur, e_dv;
    logic [63:0] e_dd;
    logic [1:0]  e_occ;
    logic [3:0]  e_cnt;
  } vec_t;
  vec_t vecs[$];

  logic [63:0] src, exp_out;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(64), .BUBBLE_DATA(BUB), .SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .up_valid(up_valid), .up_ready(up_ready_s), .up_data(up_data),
    .dn_valid(dn_valid_s), .dn_ready(dn_ready), .dn_data(dn_data_s),
    .occupancy(occ_s), .stall_cnt(cnt_s)
  );

  pipe_skid_reg #(.DATA_W(64), .BUBBLE_DATA(BUB), .SKID(0), .CNT_W(4)) u_noskid (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .up_valid(up_valid), .up_ready(up_ready_n), .up_data(up_data),
    .dn_valid(dn_valid_n), .dn_ready(dn_ready), .dn_data(dn_data_n),
    .occupancy(occ_n), .stall_cnt(cnt_n)
  );

  function automatic void add_vec(input logic r, input logic f, input logic h,
                                  input logic v, input logic [63:0] d, input logic rdy,
                                  input logic eur, input logic edv, input logic [63:0] edd,
                                  input logic [1:0] eocc, input logic [3:0] ecnt);
    vec_t t;
    t.rst = r; t.flush = f; t.hold = h; t.up_valid = v; t.up_data = d; t.dn_ready = rdy;
    t.e_ur = eur; t.e_dv = edv; t.e_dd = edd; t.e_occ = eocc; t.e_cnt = ecnt;
    vecs.push_back(t);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkModel(input int s, input string tag, input logic ur, input logic dv,
                            input logic [63:0] dd, input logic [1:0] occ,
                            input logic [3:0] sc, input bit chk);
    logic        e_ur, e_dv;
    logic [63:0] e_dd;
    if (s == 1) e_ur = !hold && (n_ent[s] < 2);
    else        e_ur = !hold && ((n_ent[s] == 0) || dn_ready);
    e_dv = !hold && (n_ent[s] > 0);
    e_dd = (n_ent[s] > 0) ? ent[s][0] : BUB;
    if (chk) begin
      checkOutput({tag, "_up_ready"},  64'(ur),  64'(e_ur));
      checkOutput({tag, "_dn_valid"},  64'(dv),  64'(e_dv));
      checkOutput({tag, "_dn_data"},   dd,       e_dd);
      checkOutput({tag, "_occupancy"}, 64'(occ), 64'(n_ent[s]));
      checkOutput({tag, "_stall_cnt"}, 64'(sc),  64'(scnt[s]));
    end
    if (rst) begin
      n_ent[s] = 0;
      scnt[s]  = 0;
    end else if (flush) begin
      n_ent[s] = 0;
    end else begin
      if (up_valid && !e_ur && scnt[s] < 15) scnt[s]++;
      if (!hold) begin
        if (e_dv && dn_ready) begin
          ent[s][0] = ent[s][1];
          n_ent[s]--;
        end
        if (up_valid && e_ur) begin
          ent[s][n_ent[s]] = up_data;
          n_ent[s]++;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic h, input logic v,
                               input logic [63:0] d, input logic rdy, input bit chk);
    @(negedge clk);
    rst = r; flush = f; hold = h; up_valid = v; up_data = d; dn_ready = rdy;
    #1;
    checkModel(1, "skid",   up_ready_s, dn_valid_s, dn_data_s, occ_s, cnt_s, chk);
    checkModel(0, "noskid", up_ready_n, dn_valid_n, dn_data_n, occ_n, cnt_n, chk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0; up_valid = 1'b0; dn_ready = 1'b1; up_data = '0;
    for (int i = 0; i < 2; i++) begin
      n_ent[i] = 0;
      scnt[i]  = 0;
      ent[i][0] = BUB;
      ent[i][1] = BUB;
    end

    // Directed table for the skid instance (CNT_W = 4).
    add_vec(1'b0,1'b0,1'b0,1'b0,64'h0,1'b1, 1'b1,1'b0,BUB,2'd0,4'd0);
    for (int i = 1; i <= 8; i++) begin
      add_vec(1'b0,1'b0,1'b0,1'b1,64'(i),1'b1, 1'b1,(i > 1),(i > 1) ? 64'(i-1) : BUB,
              (i > 1) ? 2'd1 : 2'd0, 4'd0);
    end
    add_vec(1'b0,1'b0,1'b0,1'b0,64'h0,1'b1, 1'b1,1'b1,64'h8,2'd1,4'd0);
    add_vec(1'b0,1'b0,1'b0,1'b0,64'h0,1'b1, 1'b1,1'b0,BUB,2'd0,4'd0);
    add_vec(1'b0,1'b0,1'b0,1'b1,64'hAAAA,1'b1, 1'b1,1'b0,BUB,2'd0,4'd0);
    add_vec(1'b0,1'b0,1'b0,1'b1,64'hBBBB,1'b0, 1'b1,1'b1,64'hAAAA,2'd1,4'd0);
    add_vec(1'b0,1'b0,1'b0,1'b1,64'hCCCC,1'b0, 1'b0,1'b1,64'hAAAA,2'd2,4'd0);
    add_vec(1'b0,1'b0,1'b0,1'b1,64'hCCCC,1'b0, 1'b0,1'b1,64'hAAAA,2'd2,4'd1);
    add_vec(1'b0,1'b0,1'b0,1'b1,64'hCCCC,1'b1, 1'b0,1'b1,64'hAAAA,2'd2,4'd2);
    add_vec(1'b0,1'b0,1'b0,1'b1,64'hCCCC,1'b1, 1'b1,1'b1,64'hBBBB,2'd1,4'd3);
    add_vec(1'b0,1'b0,1'b0,1'b0,64'h0,1'b1, 1'b1,1'b1,64'hCCCC,2'd1,4'd3);
    add_vec(1'b0,1'b0,1'b0,1'b0,64'h0,1'b1, 1'b1,1'b0,BUB,2'd0,4'd3);
    add_vec(1'b0,1'b0,1'b0,1'b1,64'hAAAA,1'b0, 1'b1,1'b0,BUB,2'd0,4'd3);
    add_vec(1'b0,1'b0,1'b0,1'b1,64'hBBBB,1'b0, 1'b1,1'b1,64'hAAAA,2'd1,4'd3);
    add_vec(1'b0,1'b1,1'b0,1'b1,64'h5555,1'b0, 1'b0,1'b1,64'hAAAA,2'd2,4'd3);
    add_vec(1'b0,1'b0,1'b0,1'b0,64'h0,1'b1, 1'b1,1'b0,BUB,2'd0,4'd3);
    add_vec(1'b0,1'b0,1'b0,1'b1,64'hAAAA,1'b1, 1'b1,1'b0,BUB,2'd0,4'd3);
    for (int i = 0; i < 3; i++) begin
      add_vec(1'b0,1'b0,1'b1,1'b0,64'h0,1'b1, 1'b0,1'b0,64'hAAAA,2'd1,4'd3);
    end
    add_vec(1'b0,1'b0,1'b0,1'b0,64'h0,1'b1, 1'b1,1'b1,64'hAAAA,2'd1,4'd3);
    add_vec(1'b0,1'b0,1'b0,1'b0,64'h0,1'b1, 1'b1,1'b0,BUB,2'd0,4'd3);
    for (int k = 0; k < 20; k++) begin
      add_vec(1'b0,1'b0,1'b1,1'b1,64'h77,1'b1, 1'b0,1'b0,BUB,2'd0,
              (3 + k > 15) ? 4'd15 : 4'(3 + k));
    end
    add_vec(1'b0,1'b1,1'b0,1'b1,64'h77,1'b1, 1'b1,1'b0,BUB,2'd0,4'd15);
    add_vec(1'b0,1'b0,1'b0,1'b0,64'h0,1'b1, 1'b1,1'b0,BUB,2'd0,4'd15);
    add_vec(1'b1,1'b0,1'b0,1'b0,64'h0,1'b1, 1'b1,1'b0,BUB,2'd0,4'd15);
    add_vec(1'b0,1'b0,1'b0,1'b0,64'h0,1'b1, 1'b1,1'b0,BUB,2'd0,4'd0);

    applyStimulus(1'b1,1'b0,1'b0,1'b0,64'h0,1'b1,1'b0);
    applyStimulus(1'b1,1'b0,1'b0,1'b0,64'h0,1'b1,1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].hold, vecs[i].up_valid,
                    vecs[i].up_data, vecs[i].dn_ready, 1'b1);
      checkOutput($sformatf("tbl%0d_up_ready", i),  64'(up_ready_s), 64'(vecs[i].e_ur));
      checkOutput($sformatf("tbl%0d_dn_valid", i),  64'(dn_valid_s), 64'(vecs[i].e_dv));
      checkOutput($sformatf("tbl%0d_dn_data", i),   dn_data_s,       vecs[i].e_dd);
      checkOutput($sformatf("tbl%0d_occupancy", i), 64'(occ_s),      64'(vecs[i].e_occ));
      checkOutput($sformatf("tbl%0d_stall_cnt", i), 64'(cnt_s),      64'(vecs[i].e_cnt));
    end

    // Non-skid instance: continuous source against dn_ready toggling 1,0,1,0...
    applyStimulus(1'b1,1'b0,1'b0,1'b0,64'h0,1'b1,1'b1);
    src     = 64'd1;
    exp_out = 64'd1;
    for (int i = 0; i < 16; i++) begin
      logic rdy;
      rdy = (i % 2 == 0);
      applyStimulus(1'b0,1'b0,1'b0,1'b1,src,rdy,1'b1);
      if (i >= 1) checkOutput($sformatf("ns_ready_follows_%0d", i), 64'(up_ready_n), 64'(rdy));
      if (dn_valid_n && rdy) begin
        checkOutput("ns_order", dn_data_n, exp_out);
        exp_out = exp_out + 64'd1;
      end
      if (up_ready_n) src = src + 64'd1;
    end
    checkOutput("ns_out_count", exp_out, 64'd8);
    checkOutput("ns_in_count", src, 64'd9);

    // Randomised traffic with occasional hold, flush and reset.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                    ($urandom_range(4) == 0), ($urandom_range(3) != 0),
                    {$urandom, $urandom}, ($urandom_range(2) != 0), 1'b1);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
